// File: rtl/karatsuba_seq_mul.sv
// Sequential Karatsuba multiplier: one shared booth core computes P0, P1, P2 in turn, then a combine cycle.
// Optional macro KARATSUBA_MUL_OUTREG_EN adds a booth product pipeline register and WAIT states.

module booth #(
  parameter int WA = 18,
  parameter int WP = 36
) (
  input  logic [WA-1:0] a,
  input  logic [WA-1:0] b,
  output logic [WP-1:0] p
);
  logic signed [WP-1:0] a_ext;
  logic signed [WP-1:0] b_ext;

  assign a_ext = WP'($signed(a));
  assign b_ext = WP'($signed(b));
  assign p     = a_ext * b_ext;
endmodule

module karatsuba_seq_mul #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out,
  output logic           busy
);
  localparam int H = N / 2;
  localparam int W = H + 2;

  if (((N % 2) != 0) || (N < 4)) begin : g_bad_width
    $error("karatsuba_seq_mul: N must be even and >= 4");
  end

`ifdef KARATSUBA_MUL_OUTREG_EN
  typedef enum logic [3:0] {IDLE, LO, LO_W, MID, MID_W, HI, HI_W, COMB, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LO, MID, HI, COMB, DONE} state_t;
`endif

  state_t state, state_nxt;

  logic [N-1:0]   a_r, b_r;
  logic [W-1:0]   op_a, op_b;
  logic [2*W-1:0] prod, prod_src;
  logic [N+3:0]   p0, p1, p2, mid;
  logic [2*N+1:0] sum_full;
  logic           sum_unused;
  logic           cap0, cap1, cap2;
  logic [H:0]     sum_a, sum_b;

  assign sum_a = {1'b0, a_r[H-1:0]} + {1'b0, a_r[N-1:H]};
  assign sum_b = {1'b0, b_r[H-1:0]} + {1'b0, b_r[N-1:H]};

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      LO:  begin op_a = {2'b00, a_r[H-1:0]}; op_b = {2'b00, b_r[H-1:0]}; end
      MID: begin op_a = {1'b0, sum_a};       op_b = {1'b0, sum_b};       end
      HI:  begin op_a = {2'b00, a_r[N-1:H]}; op_b = {2'b00, b_r[N-1:H]}; end
      default: ;
    endcase
  end

  booth #(.WA(W), .WP(2*W)) u_booth (.a(op_a), .b(op_b), .p(prod));

`ifdef KARATSUBA_MUL_OUTREG_EN
  logic [2*W-1:0] prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prod_q <= '0;
    else     prod_q <= prod;
  end

  assign prod_src = prod_q;
  assign cap0     = (state == LO_W);
  assign cap1     = (state == MID_W);
  assign cap2     = (state == HI_W);
`else
  assign prod_src = prod;
  assign cap0     = (state == LO);
  assign cap1     = (state == MID);
  assign cap2     = (state == HI);
`endif

  // Middle term is always non-negative, so N+4 bits hold it without wrap.
  assign mid        = p1 - p0 - p2;
  assign sum_full   = ({{(N-2){1'b0}}, p2} << N) + ({{(N-2){1'b0}}, mid} << H)
                    + {{(N-2){1'b0}}, p0};
  assign sum_unused = |sum_full[2*N+1:2*N];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = LO;
`ifdef KARATSUBA_MUL_OUTREG_EN
      LO:      state_nxt = LO_W;
      LO_W:    state_nxt = MID;
      MID:     state_nxt = MID_W;
      MID_W:   state_nxt = HI;
      HI:      state_nxt = HI_W;
      HI_W:    state_nxt = COMB;
`else
      LO:      state_nxt = MID;
      MID:     state_nxt = HI;
      HI:      state_nxt = COMB;
`endif
      COMB:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      p0        <= '0;
      p1        <= '0;
      p2        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if ((state == IDLE) && in_valid) begin
        a_r <= A;
        b_r <= B;
      end
      if (cap0) p0 <= prod_src;
      if (cap1) p1 <= prod_src;
      if (cap2) p2 <= prod_src;
      if (state == COMB) begin
        out       <= sum_full[2*N-1:0];
        out_valid <= 1'b1;
      end else if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
endmodule
